// File: rtl/poly_wave_oscillator.sv
// Purpose: time-multiplexed multi-voice oscillator (sine/saw/square/triangle) mixing all voices into one sample.
// Latency: mix_valid and mix_out update VOICES+3 cycles after an accepted sample_tick; one voice issued per cycle.
// Backpressure: none; a sample_tick arriving while busy is dropped and reported with a one-cycle overrun pulse.
module poly_wave_oscillator #(
    parameter int VOICES  = 8,
    parameter int PHASE_W = 32,
    parameter int ROM_AW  = 13,
    parameter int OUT_W   = 24,
    parameter int VOL_W   = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_tick,
    input  logic                      cfg_we,
    input  logic [$clog2(VOICES)-1:0] cfg_voice,
    input  logic [PHASE_W-1:0]        cfg_inc,
    input  logic [1:0]                cfg_wave,
    input  logic [VOL_W-1:0]          cfg_volume,
    input  logic                      cfg_gate,
    output logic [ROM_AW-1:0]         rom_addr,
    input  logic [OUT_W-1:0]          rom_q,
    output logic [OUT_W-1:0]          mix_out,
    output logic                      mix_valid,
    output logic                      busy,
    output logic                      overrun
);
    localparam int VW     = $clog2(VOICES);
    localparam int ACC_W  = OUT_W + VW;
    localparam int PROD_W = OUT_W + VOL_W;
    localparam logic [VW-1:0] LAST_V = VW'(VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [VW-1:0]   v, v_nx;
    logic            drain_cnt, drain_cnt_nx;
    logic            start, issue, frame_end;

    // Per-voice register file
    logic [PHASE_W-1:0] inc_r   [VOICES];
    logic [1:0]         wave_r  [VOICES];
    logic [VOL_W-1:0]   vol_r   [VOICES];
    logic [PHASE_W-1:0] phase_r [VOICES];
    logic [VOICES-1:0]  gate_r;

    // Stage 1: issued voice snapshot (pre-update phase), ROM data arrives this stage
    logic               s1_vld;
    logic [OUT_W-1:0]   s1_p;
    logic [1:0]         s1_wave;
    logic [VOL_W-1:0]   s1_vol;
    logic               s1_gate;
    logic [OUT_W-1:0]   p_dbl, wave_sel;

    // Stage 2: selected waveform, scaled and accumulated
    logic               s2_vld;
    logic [OUT_W-1:0]   s2_wave;
    logic [VOL_W-1:0]   s2_vol;
    logic               s2_gate;
    logic [PROD_W-1:0]  prod;
    logic [OUT_W-1:0]   scaled;
    logic [ACC_W-1:0]   acc, acc_nx;

    // FSM state register with voice index and drain counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            v         <= '0;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nx;
            v         <= v_nx;
            drain_cnt <= drain_cnt_nx;
        end
    end

    // FSM next state: IDLE -> ISSUE (one voice per cycle) -> DRAIN (2 cycles) -> IDLE
    always_comb begin
        state_nx     = state;
        v_nx         = v;
        drain_cnt_nx = drain_cnt;
        case (state)
            S_IDLE: begin
                if (sample_tick) begin
                    state_nx = S_ISSUE;
                    v_nx     = '0;
                end
            end
            S_ISSUE: begin
                if (v == LAST_V) begin
                    state_nx     = S_DRAIN;
                    drain_cnt_nx = 1'b0;
                end else begin
                    v_nx = v + VW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_cnt) begin
                    state_nx = S_IDLE;
                end else begin
                    drain_cnt_nx = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM outputs; busy drops in the same cycle mix_valid pulses so a tick there is accepted
    always_comb begin
        busy      = (state != S_IDLE);
        start     = (state == S_IDLE) && sample_tick;
        issue     = (state == S_ISSUE);
        frame_end = (state == S_DRAIN) && drain_cnt;
    end

    // ROM address from the issuing voice's current (pre-update) phase
    always_comb begin
        rom_addr = '0;
        if (issue) begin
            rom_addr = ROM_AW'(phase_r[v] >> (PHASE_W - ROM_AW));
        end
    end

    // Register file: config writes win over the issue-time phase advance; note-on hard-syncs phase
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < VOICES; i++) begin
                inc_r[i]   <= '0;
                wave_r[i]  <= '0;
                vol_r[i]   <= '0;
                phase_r[i] <= '0;
            end
            gate_r <= '0;
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                if (cfg_we && cfg_voice == VW'(i)) begin
                    inc_r[i]  <= cfg_inc;
                    wave_r[i] <= cfg_wave;
                    vol_r[i]  <= cfg_volume;
                    gate_r[i] <= cfg_gate;
                end
                if (cfg_we && cfg_voice == VW'(i) && cfg_gate && !gate_r[i]) begin
                    phase_r[i] <= '0;
                end else if (issue && v == VW'(i) && gate_r[i]) begin
                    phase_r[i] <= phase_r[i] + inc_r[i];
                end
            end
        end
    end

    // Stage 0 -> 1: capture the issued voice using the values before any same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_p    <= '0;
            s1_wave <= '0;
            s1_vol  <= '0;
            s1_gate <= 1'b0;
        end else begin
            s1_vld  <= issue;
            s1_p    <= OUT_W'(phase_r[v] >> (PHASE_W - OUT_W));
            s1_wave <= wave_r[v];
            s1_vol  <= vol_r[v];
            s1_gate <= gate_r[v];
        end
    end

    // Stage 1 waveform select; triangle folds the doubled phase on the MSB
    always_comb begin
        p_dbl    = s1_p << 1;
        wave_sel = '0;
        case (s1_wave)
            2'd0:    wave_sel = rom_q;
            2'd1:    wave_sel = s1_p;
            2'd2:    wave_sel = s1_p[OUT_W-1] ? '1 : '0;
            default: wave_sel = s1_p[OUT_W-1] ? ~p_dbl : p_dbl;
        endcase
    end

    // Stage 1 -> 2 pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_vld  <= 1'b0;
            s2_wave <= '0;
            s2_vol  <= '0;
            s2_gate <= 1'b0;
        end else begin
            s2_vld  <= s1_vld;
            s2_wave <= wave_sel;
            s2_vol  <= s1_vol;
            s2_gate <= s1_gate;
        end
    end

    // Stage 2: exact product, drop VOL_W fraction bits, ungated voices contribute nothing
    always_comb begin
        prod   = PROD_W'(s2_wave) * PROD_W'(s2_vol);
        scaled = s2_gate ? OUT_W'(prod >> VOL_W) : '0;
        acc_nx = s2_vld ? (acc + ACC_W'(scaled)) : acc;
    end

    // Accumulator, averaged output at frame end, overrun flag
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            mix_valid <= frame_end;
            overrun   <= sample_tick && busy;
            acc       <= start ? '0 : acc_nx;
            if (frame_end) begin
                mix_out <= OUT_W'(acc_nx >> VW);
            end
        end
    end

endmodule
